// File: rtl/rv32i_pkg.sv
// RV32I opcode constants and immediate-format helpers shared by the decode stage.
package rv32i_pkg;

    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_FENCE  = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_NONE = 3'd0,
        IMM_I    = 3'd1,
        IMM_S    = 3'd2,
        IMM_B    = 3'd3,
        IMM_U    = 3'd4,
        IMM_J    = 3'd5
    } imm_fmt_e;

    function automatic logic is_legal_op(input logic [6:0] op);
        case (op)
            OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD,
            OP_STORE, OP_IMM, OP_REG, OP_FENCE, OP_SYSTEM: is_legal_op = 1'b1;
            default:                                       is_legal_op = 1'b0;
        endcase
    endfunction

    // R-type and unknown opcodes carry no immediate.
    function automatic imm_fmt_e imm_fmt(input logic [6:0] op);
        case (op)
            OP_IMM, OP_LOAD, OP_JALR, OP_FENCE, OP_SYSTEM: imm_fmt = IMM_I;
            OP_STORE:                                      imm_fmt = IMM_S;
            OP_BRANCH:                                     imm_fmt = IMM_B;
            OP_LUI, OP_AUIPC:                              imm_fmt = IMM_U;
            OP_JAL:                                        imm_fmt = IMM_J;
            default:                                       imm_fmt = IMM_NONE;
        endcase
    endfunction

    function automatic logic signed [31:0] gen_imm(input imm_fmt_e fmt, input logic [31:0] i);
        case (fmt)
            IMM_I:   gen_imm = {{20{i[31]}}, i[31:20]};
            IMM_S:   gen_imm = {{20{i[31]}}, i[31:25], i[11:7]};
            IMM_B:   gen_imm = {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
            IMM_U:   gen_imm = {i[31:12], 12'h000};
            IMM_J:   gen_imm = {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
            default: gen_imm = '0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_regfile.sv
// Two-read, one-write register file with x0 hardwired to zero and write-through bypass.
module regfile
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            we,
    input  logic [4:0]      waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [4:0]      raddr1,
    input  logic [4:0]      raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2
);

    logic [XLEN-1:0] regs [NREGS];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (we && waddr != 5'd0) begin
            regs[waddr] <= wdata;
        end
    end

    // A same-cycle write to the addressed register is forwarded so decode sees the new value.
    always_comb begin
        rdata1 = regs[raddr1];
        rdata2 = regs[raddr2];
        if (raddr1 == 5'd0) begin
            rdata1 = '0;
        end else if (we && waddr == raddr1) begin
            rdata1 = wdata;
        end
        if (raddr2 == 5'd0) begin
            rdata2 = '0;
        end else if (we && waddr == raddr2) begin
            rdata2 = wdata;
        end
    end

endmodule

// File: rtl/decode_stage.sv
// RV32I ID stage: decodes fetch output, reads operands, registers the ID/EX bundle
// and inserts a single bubble on a load-use hazard by parking the instruction in a hold register.
module decode_stage
    import rv32i_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            decode_en,
    input  logic [XLEN-1:0] instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] pcp4,
    input  logic            flush,
    input  logic            wb_we,
    input  logic [4:0]      wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic            stall,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_pcp4,
    output logic [XLEN-1:0] ex_rs1_val,
    output logic [XLEN-1:0] ex_rs2_val,
    output logic [XLEN-1:0] ex_imm,
    output logic [4:0]      ex_rd,
    output logic [6:0]      ex_opcode,
    output logic [2:0]      ex_funct3,
    output logic            ex_funct7b5,
    output logic            ex_is_load,
    output logic            ex_illegal
);

    logic            hold_valid;
    logic [XLEN-1:0] hold_instr;
    logic [XLEN-1:0] hold_pc;
    logic [XLEN-1:0] hold_pcp4;

    logic            src_valid;
    logic [31:0]     src_instr;
    logic [XLEN-1:0] src_pc;
    logic [XLEN-1:0] src_pcp4;

    logic [6:0]      dec_op;
    logic [4:0]      dec_rd;
    logic [4:0]      dec_rs1;
    logic [4:0]      dec_rs2;
    logic            dec_legal;
    logic            rs1_used;
    logic            rs2_used;
    logic signed [31:0]   dec_imm32;
    logic [XLEN-1:0] dec_imm;
    logic [XLEN-1:0] rs1_val;
    logic [XLEN-1:0] rs2_val;
    logic            haz;
    logic            wr_en;

    // ---- source select: a parked instruction always wins over fetch ----
    always_comb begin
        src_valid = hold_valid | decode_en;
        src_instr = hold_valid ? hold_instr[31:0] : instr[31:0];
        src_pc    = hold_valid ? hold_pc   : pc;
        src_pcp4  = hold_valid ? hold_pcp4 : pcp4;
    end

    always_comb begin
        dec_op    = src_instr[6:0];
        dec_rs1   = src_instr[19:15];
        dec_rs2   = src_instr[24:20];
        dec_legal = is_legal_op(dec_op);
        dec_rd    = (dec_legal && dec_op != OP_STORE && dec_op != OP_BRANCH) ?
                    src_instr[11:7] : 5'd0;
        rs1_used  = (dec_op != OP_LUI) && (dec_op != OP_AUIPC) && (dec_op != OP_JAL);
        rs2_used  = (dec_op == OP_REG) || (dec_op == OP_STORE) || (dec_op == OP_BRANCH);
        dec_imm32 = gen_imm(dec_legal ? imm_fmt(dec_op) : IMM_NONE, src_instr);
        dec_imm   = XLEN'(dec_imm32);
    end

    assign wr_en = en & wb_we;

    regfile #(
        .XLEN  (XLEN),
        .NREGS (NREGS)
    ) u_regfile (
        .clk    (clk),
        .rst    (rst),
        .we     (wr_en),
        .waddr  (wb_rd),
        .wdata  (wb_data),
        .raddr1 (dec_rs1),
        .raddr2 (dec_rs2),
        .rdata1 (rs1_val),
        .rdata2 (rs2_val)
    );

    always_comb begin
        haz = ex_valid && ex_is_load && (ex_rd != 5'd0) && src_valid &&
              ((rs1_used && dec_rs1 == ex_rd) || (rs2_used && dec_rs2 == ex_rd));
        stall = en && !flush && haz;
    end

    // ---- ID/EX boundary ----
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            hold_valid  <= 1'b0;
            hold_instr  <= '0;
            hold_pc     <= '0;
            hold_pcp4   <= '0;
            ex_valid    <= 1'b0;
            ex_pc       <= '0;
            ex_pcp4     <= '0;
            ex_rs1_val  <= '0;
            ex_rs2_val  <= '0;
            ex_imm      <= '0;
            ex_rd       <= '0;
            ex_opcode   <= '0;
            ex_funct3   <= '0;
            ex_funct7b5 <= 1'b0;
            ex_is_load  <= 1'b0;
            ex_illegal  <= 1'b0;
        end else if (en) begin
            if (flush) begin
                ex_valid   <= 1'b0;
                hold_valid <= 1'b0;
            end else if (haz) begin
                ex_valid   <= 1'b0;
                hold_valid <= 1'b1;
                hold_instr <= XLEN'(src_instr);
                hold_pc    <= src_pc;
                hold_pcp4  <= src_pcp4;
            end else if (src_valid) begin
                ex_valid    <= 1'b1;
                hold_valid  <= 1'b0;
                ex_pc       <= src_pc;
                ex_pcp4     <= src_pcp4;
                ex_rs1_val  <= rs1_val;
                ex_rs2_val  <= rs2_val;
                ex_imm      <= dec_imm;
                ex_rd       <= dec_rd;
                ex_opcode   <= dec_op;
                ex_funct3   <= src_instr[14:12];
                ex_funct7b5 <= src_instr[30];
                ex_is_load  <= (dec_op == OP_LOAD);
                ex_illegal  <= !dec_legal;
            end else begin
                ex_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, bypass, load-use bubble, flush, enable and reset.
module tb_decode_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        decode_en;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcp4;
    logic        flush;
    logic        wb_we;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        stall;
    logic        ex_valid;
    logic [31:0] ex_pc;
    logic [31:0] ex_pcp4;
    logic [31:0] ex_rs1_val;
    logic [31:0] ex_rs2_val;
    logic [31:0] ex_imm;
    logic [4:0]  ex_rd;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_funct3;
    logic        ex_funct7b5;
    logic        ex_is_load;
    logic        ex_illegal;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    decode_stage dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .decode_en   (decode_en),
        .instr       (instr),
        .pc          (pc),
        .pcp4        (pcp4),
        .flush       (flush),
        .wb_we       (wb_we),
        .wb_rd       (wb_rd),
        .wb_data     (wb_data),
        .stall       (stall),
        .ex_valid    (ex_valid),
        .ex_pc       (ex_pc),
        .ex_pcp4     (ex_pcp4),
        .ex_rs1_val  (ex_rs1_val),
        .ex_rs2_val  (ex_rs2_val),
        .ex_imm      (ex_imm),
        .ex_rd       (ex_rd),
        .ex_opcode   (ex_opcode),
        .ex_funct3   (ex_funct3),
        .ex_funct7b5 (ex_funct7b5),
        .ex_is_load  (ex_is_load),
        .ex_illegal  (ex_illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [31:0] ins, input logic [31:0] p);
        decode_en = v;
        instr     = ins;
        pc        = p;
        pcp4      = p + 32'd4;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    localparam logic [31:0] I_ADDI_X1_5  = 32'h0050_0093;
    localparam logic [31:0] I_ADD_4_3_0  = 32'h0001_8233;
    localparam logic [31:0] I_LW_5_2     = 32'h0001_2283;
    localparam logic [31:0] I_ADD_6_5_5  = 32'h0052_8333;
    localparam logic [31:0] I_BEQ_M8     = 32'hFE00_0CE3;
    localparam logic [31:0] I_JAL_2048   = 32'h0010_00EF;
    localparam logic [31:0] I_LUI_7      = 32'h1234_53B7;
    localparam logic [31:0] I_ADD_4_0_0  = 32'h0000_0233;
    localparam logic [31:0] I_ADD_4_9_0  = 32'h0004_8233;

    initial begin
        rst = 1'b0; en = 1'b1; flush = 1'b0;
        wb_we = 1'b0; wb_rd = 5'd0; wb_data = '0;
        drv(1'b0, '0, '0);
        #12;
        check("rst_ex_valid", 32'(ex_valid), 32'd0);
        check("rst_stall",    32'(stall), 32'd0);
        check("rst_hold",     32'(dut.hold_valid), 32'd0);
        check("rst_ex_pc",    ex_pc, 32'd0);
        check("rst_ex_imm",   ex_imm, 32'd0);
        @(negedge clk) rst = 1'b1;

        // addi x1,x0,5
        @(negedge clk) drv(1'b1, I_ADDI_X1_5, 32'h0);
        cyc();
        check("addi_valid", 32'(ex_valid), 32'd1);
        check("addi_rd",    32'(ex_rd), 32'd1);
        check("addi_imm",   ex_imm, 32'd5);
        check("addi_rs1",   ex_rs1_val, 32'd0);
        check("addi_pcp4",  ex_pcp4, 32'd4);
        check("addi_op",    32'(ex_opcode), 32'h13);

        // write-through bypass, then the stored value
        @(negedge clk);
        drv(1'b1, I_ADD_4_3_0, 32'h4);
        wb_we = 1'b1; wb_rd = 5'd3; wb_data = 32'hDEADBEEF;
        cyc();
        check("byp_rs1", ex_rs1_val, 32'hDEADBEEF);
        check("byp_rd",  32'(ex_rd), 32'd4);
        check("byp_imm", ex_imm, 32'd0);
        @(negedge clk);
        wb_we = 1'b0;
        drv(1'b1, I_ADD_4_3_0, 32'h8);
        cyc();
        check("rf_rs1", ex_rs1_val, 32'hDEADBEEF);

        // load-use: one stall cycle, one bubble
        @(negedge clk) drv(1'b1, I_LW_5_2, 32'h0);
        cyc();
        check("lw_is_load", 32'(ex_is_load), 32'd1);
        check("lw_rd",      32'(ex_rd), 32'd5);
        @(negedge clk) drv(1'b1, I_ADD_6_5_5, 32'h4);
        #1 check("lu_stall", 32'(stall), 32'd1);
        cyc();
        check("lu_bubble", 32'(ex_valid), 32'd0);
        check("lu_hold",   32'(dut.hold_valid), 32'd1);
        check("lu_stall_gone", 32'(stall), 32'd0);
        cyc();
        check("lu_issue_valid", 32'(ex_valid), 32'd1);
        check("lu_issue_pc",    ex_pc, 32'd4);
        check("lu_issue_rd",    32'(ex_rd), 32'd6);
        check("lu_hold_clr",    32'(dut.hold_valid), 32'd0);
        @(negedge clk) decode_en = 1'b0;
        cyc();
        check("idle_valid", 32'(ex_valid), 32'd0);
        check("idle_pc",    ex_pc, 32'd4);

        // immediate formats
        @(negedge clk) drv(1'b1, I_BEQ_M8, 32'h8);
        cyc();
        check("beq_imm", ex_imm, 32'hFFFFFFF8);
        check("beq_rd",  32'(ex_rd), 32'd0);
        @(negedge clk) drv(1'b1, I_JAL_2048, 32'hC);
        cyc();
        check("jal_imm", ex_imm, 32'h00000800);
        check("jal_rd",  32'(ex_rd), 32'd1);
        @(negedge clk) drv(1'b1, I_LUI_7, 32'h10);
        cyc();
        check("lui_imm", ex_imm, 32'h12345000);
        check("lui_rd",  32'(ex_rd), 32'd7);

        // flush during a load-use stall
        @(negedge clk) drv(1'b1, I_LW_5_2, 32'h20);
        cyc();
        @(negedge clk);
        drv(1'b1, I_ADD_6_5_5, 32'h24);
        flush = 1'b1;
        #1 check("fl_stall", 32'(stall), 32'd0);
        cyc();
        check("fl_valid", 32'(ex_valid), 32'd0);
        check("fl_hold",  32'(dut.hold_valid), 32'd0);
        check("fl_stall_after", 32'(stall), 32'd0);
        @(negedge clk);
        flush = 1'b0;
        drv(1'b1, I_ADDI_X1_5, 32'h40);
        cyc();
        check("fl_next_valid", 32'(ex_valid), 32'd1);
        check("fl_next_pc",    ex_pc, 32'h40);

        // illegal opcode
        @(negedge clk) drv(1'b1, 32'hFFFFFFFF, 32'h44);
        cyc();
        check("ill_flag",  32'(ex_illegal), 32'd1);
        check("ill_valid", 32'(ex_valid), 32'd1);
        check("ill_imm",   ex_imm, 32'd0);

        // write to x0 is discarded
        @(negedge clk);
        decode_en = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd0; wb_data = 32'h00001234;
        cyc();
        @(negedge clk);
        wb_we = 1'b0;
        drv(1'b1, I_ADD_4_0_0, 32'h60);
        cyc();
        check("x0_rs1", ex_rs1_val, 32'd0);

        // en=0 freezes everything, including regfile writes
        @(negedge clk);
        en = 1'b0;
        wb_we = 1'b1; wb_rd = 5'd9; wb_data = 32'h00000055;
        drv(1'b1, I_ADDI_X1_5, 32'h80);
        cyc();
        check("en0_pc",    ex_pc, 32'h60);
        check("en0_valid", 32'(ex_valid), 32'd1);
        @(negedge clk);
        en = 1'b1;
        wb_we = 1'b0;
        drv(1'b1, I_ADD_4_9_0, 32'h84);
        cyc();
        check("en0_nowrite", ex_rs1_val, 32'd0);
        check("en1_pc",      ex_pc, 32'h84);

        // asynchronous reset in the middle of a stall
        @(negedge clk) drv(1'b1, I_LW_5_2, 32'h90);
        cyc();
        @(negedge clk) drv(1'b1, I_ADD_6_5_5, 32'h94);
        #1 check("ar_stall_pre", 32'(stall), 32'd1);
        #1 rst = 1'b0;
        #1;
        check("ar_stall", 32'(stall), 32'd0);
        check("ar_hold",  32'(dut.hold_valid), 32'd0);
        check("ar_valid", 32'(ex_valid), 32'd0);
        @(negedge clk) rst = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
